// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic array computing C = A*B over K beats, with ping-pong result banks.
// Define SYSTOLIC_SATURATE_EN for saturating accumulation and the banked per-PE ovf_flag output.
module systolic_array_nxn #(
  parameter int unsigned N          = 2,
  parameter int unsigned data_width = 8,
  parameter int unsigned acc_width  = 2 * data_width,
  parameter int unsigned K_MAX      = 16,
  localparam int unsigned CW        = $clog2(K_MAX + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CW-1:0]                  k_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N*data_width-1:0]        a_in,
  input  logic [N*data_width-1:0]        b_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N*N*acc_width-1:0]       out_c,
`ifdef SYSTOLIC_SATURATE_EN
  output logic [N*N-1:0]                 ovf_flag,
`endif
  output logic                           busy,
  output logic                           active_buffer
);

  localparam int unsigned DW  = data_width;
  localparam int unsigned AW  = acc_width;
  localparam int unsigned NN  = N * N;
  localparam int unsigned DCW = $clog2(2 * N);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StCommit} state_e;

  state_e         r_state, w_state_next;
  logic [CW-1:0]  r_k_len, r_beat_cnt, w_k_eff;
  logic [DCW-1:0] r_drain_cnt;
  logic           w_start_acc, w_beat_acc, w_adv, w_last_beat, w_drain_done;
  logic           w_release, w_bank_free, w_commit;
  logic [1:0]     r_bank_valid;
  logic           r_wr_ptr, r_rd_ptr, r_out_valid;

  logic [1:0][NN*AW-1:0]          r_bank_c;
  logic [NN-1:0][AW-1:0]          w_acc;
  logic [N-1:0][N-1:0][DW-1:0]    w_a_pe, w_b_pe;

  assign w_k_eff      = (k_len > CW'(K_MAX)) ? CW'(K_MAX) : k_len;
  assign w_start_acc  = (r_state == StIdle) && start;
  assign w_beat_acc   = (r_state == StLoad) && in_valid;
  // The array only moves on an accepted beat or while draining; LOAD bubbles freeze it.
  assign w_adv        = w_beat_acc || (r_state == StDrain);
  assign w_last_beat  = w_beat_acc && (r_beat_cnt == r_k_len - CW'(1));
  assign w_drain_done = (r_state == StDrain) && (r_drain_cnt == DCW'(2 * N - 2));
  assign w_release    = r_out_valid && out_ready;
  // A bank being released this cycle may be refilled on the same edge.
  assign w_bank_free  = !r_bank_valid[r_wr_ptr] || (w_release && (r_rd_ptr == r_wr_ptr));
  assign w_commit     = (r_state == StCommit) && w_bank_free;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (start) w_state_next = (w_k_eff == '0) ? StDrain : StLoad;
      StLoad:   if (w_last_beat) w_state_next = StDrain;
      StDrain:  if (w_drain_done) w_state_next = StCommit;
      StCommit: if (w_bank_free) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_acc) begin
        r_k_len    <= w_k_eff;
        r_beat_cnt <= '0;
      end else if (w_beat_acc) begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end
      r_drain_cnt <= (r_state == StDrain) ? r_drain_cnt + DCW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_valid <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_release) begin
        r_bank_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr               <= ~r_rd_ptr;
      end
      if (w_commit) begin
        r_bank_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      r_out_valid <= w_release ? 1'b0 : r_bank_valid[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) r_bank_c[r_wr_ptr] <= w_acc;
  end

  assign out_valid     = r_out_valid;
  assign out_c         = r_out_valid ? r_bank_c[r_rd_ptr] : '0;
  assign active_buffer = r_rd_ptr;
  assign busy          = (r_state != StIdle);
  assign in_ready      = (r_state == StLoad);

`ifdef SYSTOLIC_SATURATE_EN
  logic [1:0][NN-1:0] r_bank_ovf;
  logic [NN-1:0]      w_ovf;

  always_ff @(posedge clk) begin
    if (w_commit) r_bank_ovf[r_wr_ptr] <= w_ovf;
  end

  assign ovf_flag = r_out_valid ? r_bank_ovf[r_rd_ptr] : '0;
`endif

  // Input skew: row/column i is delayed by i advancing cycles before entering the array.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] w_a_inj, w_b_inj;
    assign w_a_inj = w_beat_acc ? a_in[i*DW +: DW] : '0;
    assign w_b_inj = w_beat_acc ? b_in[i*DW +: DW] : '0;

    if (i == 0) begin : g_direct
      assign w_a_pe[0][0] = w_a_inj;
      assign w_b_pe[0][0] = w_b_inj;
    end else begin : g_chain
      logic [i-1:0][DW-1:0] r_a_sk, r_b_sk;
      always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
          r_a_sk <= '0;
          r_b_sk <= '0;
        end else if (w_adv) begin
          r_a_sk[0] <= w_a_inj;
          r_b_sk[0] <= w_b_inj;
          for (int m = 1; m < i; m++) begin
            r_a_sk[m] <= r_a_sk[m-1];
            r_b_sk[m] <= r_b_sk[m-1];
          end
        end
      end
      assign w_a_pe[i][0] = r_a_sk[i-1];
      assign w_b_pe[0][i] = r_b_sk[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [AW-1:0] r_acc, w_acc_next, w_a_ext, w_b_ext;
      assign w_a_ext = AW'($signed(w_a_pe[i][j]));
      assign w_b_ext = AW'($signed(w_b_pe[i][j]));

`ifdef SYSTOLIC_SATURATE_EN
      localparam int unsigned SW = 2 * AW + 2;
      localparam logic signed [SW-1:0] SatMax = SW'($signed({1'b0, {(AW - 1){1'b1}}}));
      localparam logic signed [SW-1:0] SatMin = SW'($signed({1'b1, {(AW - 1){1'b0}}}));
      logic signed [SW-1:0] w_sum;
      logic                 w_ovf_now, r_ovf;

      assign w_sum = SW'(r_acc) + SW'(w_a_ext) * SW'(w_b_ext);

      always_comb begin
        w_ovf_now  = 1'b0;
        w_acc_next = w_sum[AW-1:0];
        if (w_sum > SatMax) begin
          w_ovf_now  = 1'b1;
          w_acc_next = SatMax[AW-1:0];
        end else if (w_sum < SatMin) begin
          w_ovf_now  = 1'b1;
          w_acc_next = SatMin[AW-1:0];
        end
      end

      always_ff @(posedge clk) begin
        if (rst || w_start_acc) r_ovf <= 1'b0;
        else if (w_adv)         r_ovf <= r_ovf | w_ovf_now;
      end
      assign w_ovf[i*N+j] = r_ovf;
`else
      assign w_acc_next = r_acc + w_a_ext * w_b_ext;
`endif

      always_ff @(posedge clk) begin
        if (rst || w_start_acc) r_acc <= '0;
        else if (w_adv)         r_acc <= w_acc_next;
      end
      assign w_acc[i*N+j] = r_acc;

      if (j < N - 1) begin : g_fwd_a
        logic [DW-1:0] r_a;
        always_ff @(posedge clk) begin
          if (rst || w_start_acc) r_a <= '0;
          else if (w_adv)         r_a <= w_a_pe[i][j];
        end
        assign w_a_pe[i][j+1] = r_a;
      end

      if (i < N - 1) begin : g_fwd_b
        logic [DW-1:0] r_b;
        always_ff @(posedge clk) begin
          if (rst || w_start_acc) r_b <= '0;
          else if (w_adv)         r_b <= w_b_pe[i][j];
        end
        assign w_b_pe[i+1][j] = r_b;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Scoreboard bench for systolic_array_nxn: directed jobs push expected results, monitors pop on handshake.
module tb_systolic_array_nxn;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = $clog2(16 + 1);

  typedef struct packed {
    logic [4*AW-1:0] c;
    logic            ab;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start, in_valid, out_ready, in_ready, out_valid, busy, active_buffer;
  logic [CW-1:0]   k_len;
  logic [N*DW-1:0] a_in, b_in;
  logic [4*AW-1:0] out_c;

  logic            s_start, s_in_valid, s_out_ready, s_in_ready, s_out_valid, s_busy, s_ab;
  logic [CW-1:0]   s_k_len;
  logic [N*DW-1:0] s_a, s_b;
  logic [31:0]     s_out_c;
  logic [3:0]      ovf_flag, s_ovf;

  exp_t        q_exp[$];
  logic [35:0] q8[$];
  logic        exp_ab;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  systolic_array_nxn #(.N(2), .data_width(8), .acc_width(16), .K_MAX(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready), .a_in(a_in), .b_in(b_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c),
`ifdef SYSTOLIC_SATURATE_EN
    .ovf_flag(ovf_flag),
`endif
    .busy(busy), .active_buffer(active_buffer)
  );

  systolic_array_nxn #(.N(2), .data_width(8), .acc_width(8), .K_MAX(16)) u_dut8 (
    .clk(clk), .rst(rst), .start(s_start), .k_len(s_k_len), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .a_in(s_a), .b_in(s_b), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_c(s_out_c),
`ifdef SYSTOLIC_SATURATE_EN
    .ovf_flag(s_ovf),
`endif
    .busy(s_busy), .active_buffer(s_ab)
  );

`ifndef SYSTOLIC_SATURATE_EN
  assign ovf_flag = 4'h0;
  assign s_ovf    = 4'h0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] vec2(input int e0, input int e1);
    return {8'(e1), 8'(e0)};
  endfunction

  function automatic logic [63:0] mat(input int c00, input int c01, input int c10, input int c11);
    return {16'(c11), 16'(c10), 16'(c01), 16'(c00)};
  endfunction

  task automatic push_exp(input logic [63:0] c);
    exp_t e;
    e.c  = c;
    e.ab = exp_ab;
    q_exp.push_back(e);
    exp_ab = ~exp_ab;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; s_start = 1'b0; s_in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_ab = 1'b0;
    q_exp.delete();
    q8.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic wait_drained();
    int n = 0;
    while ((q_exp.size() != 0 || q8.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q_exp.size() + q8.size());
    end
  endtask

  task automatic start_job(input int k);
    wait_idle();
    start = 1'b1;
    k_len = CW'(k);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int a0, input int a1, input int b0, input int b1, input int gaps);
    in_valid = 1'b0;
    repeat (gaps) begin
      check("in_ready_gap", 64'(in_ready), 64'(1));
      tick();
    end
    in_valid = 1'b1;
    a_in = vec2(a0, a1);
    b_in = vec2(b0, b1);
    check("in_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
  endtask

  // Main-array monitor: pops on handshake and checks hold stability while stalled.
  initial begin
    exp_t            e;
    logic            stall;
    logic [4*AW-1:0] pc;
    logic            pab;
    stall = 1'b0; pc = '0; pab = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", 64'(out_valid), 64'(1));
          check("hold_c", out_c, pc);
          check("hold_ab", 64'(active_buffer), 64'(pab));
        end
        if (out_valid && out_ready) begin
          if (q_exp.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_result: got %h expected none", out_c);
          end else begin
            e = q_exp.pop_front();
            check("out_c", out_c, e.c);
            check("active_buffer", 64'(active_buffer), 64'(e.ab));
            check("ovf_flag", 64'(ovf_flag), 64'(0));
          end
        end
        stall = out_valid && !out_ready;
        pc    = out_c;
        pab   = active_buffer;
      end
    end
  end

  initial begin
    logic [35:0] e8;
    forever begin
      @(negedge clk);
      if (!rst && s_out_valid && s_out_ready) begin
        if (q8.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result8: got %h expected none", s_out_c);
        end else begin
          e8 = q8.pop_front();
          check("out_c_acc8", 64'({s_ovf, s_out_c}), 64'(e8));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    start = 1'b0; k_len = '0; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b1;
    s_start = 1'b0; s_k_len = '0; s_in_valid = 1'b0; s_a = '0; s_b = '0; s_out_ready = 1'b1;
    exp_ab = 1'b0;
    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_active_buffer", 64'(active_buffer), 64'(0));
    check("rst_out_c", out_c, 64'(0));

    // Basic 2x2 job and output latency
    push_exp(mat(19, 22, 43, 50));
    start_job(2);
    beat(1, 3, 5, 6, 0);
    beat(2, 4, 7, 8, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(5));

    // Same job with bubbles between beats
    push_exp(mat(19, 22, 43, 50));
    start_job(2);
    beat(1, 3, 5, 6, 0);
    beat(2, 4, 7, 8, 2);
    wait_drained();

    // Three jobs under back-pressure: third waits in COMMIT
    out_ready = 1'b0;
    push_exp(mat(8, 10, 12, 15));
    start_job(1);
    beat(2, 3, 4, 5, 0);
    push_exp(mat(-3, 4, 6, -8));
    start_job(1);
    beat(-1, 2, 3, -4, 0);
    push_exp(mat(-56, 49, 64, -56));
    start_job(1);
    beat(7, -8, -8, 7, 0);
    repeat (12) tick();
    check("commit_wait_busy", 64'(busy), 64'(1));
    check("commit_wait_in_ready", 64'(in_ready), 64'(0));
    check("commit_wait_valid", 64'(out_valid), 64'(1));
    check("commit_wait_ab", 64'(active_buffer), 64'(0));
    out_ready = 1'b1;
    wait_drained();

    // Reset during DRAIN aborts the job
    start_job(2);
    beat(9, 9, 9, 9, 0);
    beat(9, 9, 9, 9, 0);
    tick();
    do_reset();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    push_exp(mat(1, 0, 0, 1));
    start_job(2);
    beat(1, 0, 1, 0, 0);
    beat(0, 1, 0, 1, 0);
    wait_drained();

    // k_len = 0 gives a zero result
    push_exp(mat(0, 0, 0, 0));
    start_job(0);
    wait_drained();

    // start pulsed during LOAD is ignored
    push_exp(mat(-16, 30, -38, 20));
    start_job(2);
    beat(1, -2, 5, 6, 0);
    start = 1'b1;
    k_len = CW'(1);
    tick();
    start = 1'b0;
    check("in_ready_start_in_load", 64'(in_ready), 64'(1));
    beat(3, 4, -7, 8, 0);
    wait_drained();

    // k_len above K_MAX clamps to 16 beats
    push_exp(mat(16, 16, 16, 16));
    start_job(20);
    repeat (16) beat(1, 1, 1, 1, 0);
    check("in_ready_after_kmax", 64'(in_ready), 64'(0));
    wait_drained();

    // 8-bit accumulator: wrap or saturate
`ifdef SYSTOLIC_SATURATE_EN
    q8.push_back({4'hf, {4{8'd127}}});
`else
    q8.push_back({4'h0, {4{8'd4}}});
`endif
    s_start = 1'b1;
    s_k_len = CW'(4);
    tick();
    s_start = 1'b0;
    repeat (4) begin
      s_in_valid = 1'b1;
      s_a = 16'h7f7f;
      s_b = 16'h7f7f;
      check("in_ready_acc8", 64'(s_in_ready), 64'(1));
      tick();
    end
    s_in_valid = 1'b0;
    wait_drained();

    check("scoreboard_empty", 64'(q_exp.size()), 64'(0));
    check("scoreboard8_empty", 64'(q8.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array_nxn.md
SYSTOLIC_ARRAY_NXN -- requirements
Module: systolic_array_nxn

Interface
REQ-001: Parameter N, default 2, array dimension; SHALL be at least 2; the array has N rows and N columns of processing elements (PEs).
REQ-002: Parameter data_width, default 8, operand width in bits, signed two's complement.
REQ-003: Parameter acc_width, default 2*data_width, accumulator width in bits, signed.
REQ-004: Parameter K_MAX, default 16, maximum reduction length; CW = clog2(K_MAX+1).
REQ-005: clk  in  1  single clock; all state changes on posedge clk.
REQ-006: rst  in  1  synchronous, active-high reset.
REQ-007: start  in  1  pulse that begins a job; sampled in IDLE only.
REQ-008: k_len  in  CW  reduction length K of the job; latched when start is accepted.
REQ-009: in_valid  in  1  a_in/b_in beat valid.
REQ-010: in_ready  out  1  array accepts a beat this cycle.
REQ-011: a_in  in  N*data_width  column k of A; element i at bits [i*data_width +: data_width].
REQ-012: b_in  in  N*data_width  row k of B; element j at bits [j*data_width +: data_width].
REQ-013: out_valid  out  1  out_c holds a complete result.
REQ-014: out_ready  in  1  consumer accepts out_c.
REQ-015: out_c  out  N*N*acc_width  C[i][j] at bits [(i*N+j)*acc_width +: acc_width].
REQ-016: busy  out  1  FSM is not in IDLE.
REQ-017: active_buffer  out  1  index of the result bank currently presented on out_c.

Function
REQ-018: FSM states SHALL be IDLE, LOAD, DRAIN and COMMIT.
- IDLE -> LOAD on start with k_len != 0.
- IDLE -> DRAIN on start with k_len == 0, giving an all-zero result.
- LOAD -> DRAIN after K accepted beats.
- DRAIN -> COMMIT after 2N-1 cycles.
- COMMIT -> IDLE once a bank is free.
REQ-019: in_ready SHALL be 1 only in LOAD; a beat is accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-020: On start acceptance, all PE accumulators SHALL clear to 0 on the same edge.
REQ-021: Row i of A SHALL enter column 0 delayed by i cycles, and column j of B SHALL enter row 0 delayed by j cycles, using internal skew registers.
REQ-022: Each PE SHALL compute acc += a*b, with a and b sign-extended to acc_width, and SHALL forward a rightward and b downward through one register stage each.
REQ-023: In any LOAD cycle with no accepted beat, the PEs and skew registers SHALL hold (array freeze), so bubbles do not corrupt results.
REQ-024: In DRAIN, the array SHALL advance every cycle with zero operands injected.
REQ-025: In COMMIT, all N*N accumulators SHALL be copied into the free bank in one cycle; out_valid SHALL rise the following cycle if it was low.
REQ-026: With a free bank and out_ready held high, out_valid SHALL rise exactly 2N+1 cycles after the edge that accepted the last beat.
REQ-027: The result banks SHALL be double-buffered (ping-pong).
- The output handshake completes when out_valid and out_ready are both 1; that bank is then released and the read pointer toggles.
- out_c and active_buffer SHALL be stable while out_valid is 1 and out_ready is 0.
REQ-028: If both banks are full at COMMIT, the FSM SHALL wait in COMMIT.
- A bank release and a commit in the same cycle SHALL both take effect.
REQ-029: start SHALL be ignored outside IDLE, and start with k_len > K_MAX SHALL be clamped to K_MAX.
REQ-030: Accumulation SHALL wrap modulo 2^acc_width unless the configuration macro in REQ-035 is defined.

Reset
REQ-031: On rst, the FSM SHALL go to IDLE and the accumulators, skew registers and both bank valid flags SHALL clear.
REQ-032: Output values after reset SHALL be in_ready=0, out_valid=0, busy=0, active_buffer=0 and out_c=0.
REQ-033: rst asserted mid-job SHALL abort the job; no partial result is ever committed.
REQ-034: rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-035: With SYSTOLIC_SATURATE_EN defined, each accumulate SHALL saturate to [-2^(acc_width-1), 2^(acc_width-1)-1].
- Each PE also keeps a sticky overflow bit.
- Output ovf_flag (out, N*N bits, bit i*N+j) SHALL be committed and banked alongside C.
- Without the macro, accumulation wraps and ovf_flag does not exist.

Verification
REQ-036: N=2, K=2, a beats {1,3},{2,4}, b beats {5,6},{7,8} -> out_c C00=19, C01=22, C10=43, C11=50; out_valid rises 5 cycles after the last beat.
REQ-037: Same job with in_valid toggling 1,0,0,1 -> identical C values, and in_ready stays high throughout LOAD.
REQ-038: Three back-to-back jobs with out_ready=0 -> the first two results are banked, the third waits in COMMIT; releasing one bank commits the third, active_buffer toggles, and all results are in order.
REQ-039: rst asserted in DRAIN of job 1, then job 2 with A=B=identity -> out_valid never shows job 1, and job 2 yields the identity matrix.
REQ-040: data_width=8, acc_width=8, K=4, all operands 127 -> wraps to 4 (result 64516 mod 256) without the macro; with the macro gives 127 and ovf_flag all-ones.
REQ-041: start with k_len=0 -> all-zero result with out_valid asserted; start pulsed during LOAD -> no effect.
